// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is combinational from pc; training comes from E-stage branch resolution.
module branch_target_predictor #(
  parameter int PC_W  = 13,
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  prepc,
  output logic             hit_predict,
  output logic [1:0]       state,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_miss
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [CNT_W-1:0]   r_cnt_branch;
  logic [CNT_W-1:0]   r_cnt_miss;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [1:0]       w_u_ctr;
  logic [1:0]       w_ctr_next;
  logic             w_wr_en;

  // Fetch-side lookup: zero latency, reflects contents before any same-cycle write.
  assign w_idx       = pc[IDX_W-1:0];
  assign w_tag       = pc[PC_W-1:IDX_W];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign hit_predict = w_hit;
  assign state       = w_hit ? r_ctr[w_idx] : 2'b00;
  assign prepc       = w_hit ? r_target[w_idx] : (pc + PC_W'(1));

  assign w_u_idx = upd_pc[IDX_W-1:0];
  assign w_u_tag = upd_pc[PC_W-1:IDX_W];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_ctr = r_ctr[w_u_idx];

  always_comb begin
    w_ctr_next = 2'b10;
    if (w_u_hit) begin
      if (upd_taken) w_ctr_next = (w_u_ctr == 2'b11) ? 2'b11 : w_u_ctr + 2'b01;
      else           w_ctr_next = (w_u_ctr == 2'b00) ? 2'b00 : w_u_ctr - 2'b01;
    end
  end

  // A not-taken miss leaves storage untouched so cold not-taken branches never evict.
  assign w_wr_en = NRST && upd_valid && (w_u_hit || upd_taken);

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_valid <= '0;
    end else if (w_wr_en) begin
      r_valid[w_u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_tag[w_u_idx] <= w_u_tag;
      r_ctr[w_u_idx] <= w_ctr_next;
      if (upd_taken) r_target[w_u_idx] <= upd_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_cnt_branch <= '0;
      r_cnt_miss   <= '0;
    end else if (upd_valid) begin
      r_cnt_branch <= r_cnt_branch + CNT_W'(1);
      r_cnt_miss   <= r_cnt_miss + CNT_W'(upd_mispredict);
    end
  end

  assign cnt_branch = r_cnt_branch;
  assign cnt_miss   = r_cnt_miss;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed-vector bench: stimulus queues expected lookup/counter values per cycle,
// a monitor pops and compares them on the falling edge of that cycle.
module tb_branch_target_predictor;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [12:0] pc;
  logic [12:0] prepc;
  logic        hit_predict;
  logic [1:0]  state;
  logic        upd_valid;
  logic [12:0] upd_pc;
  logic        upd_taken;
  logic [12:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_miss;

  branch_target_predictor #(.PC_W(13), .IDX_W(6), .CNT_W(32)) dut (
    .CLK(CLK), .NRST(NRST), .pc(pc), .prepc(prepc), .hit_predict(hit_predict),
    .state(state), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .cnt_branch(cnt_branch), .cnt_miss(cnt_miss)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    string       name;
    logic        hit;
    logic [1:0]  st;
    logic [12:0] pp;
    logic [31:0] cb;
    logic [31:0] cm;
  } exp_t;

  exp_t q[$];
  int   cyc_count = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   stim_done = 1'b0;

  always @(posedge CLK) cyc_count <= cyc_count + 1;

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc_count) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      if (e.cyc != cyc_count) begin
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc_count);
      end else if (hit_predict !== e.hit || state !== e.st || prepc !== e.pp ||
                   cnt_branch !== e.cb || cnt_miss !== e.cm) begin
        $display("FAIL %s: pc=%h got hit=%b state=%b prepc=%h cb=%0d cm=%0d, expected hit=%b state=%b prepc=%h cb=%0d cm=%0d",
                 e.name, pc, hit_predict, state, prepc, cnt_branch, cnt_miss,
                 e.hit, e.st, e.pp, e.cb, e.cm);
      end else begin
        n_pass++;
        $display("ok   %s: pc=%h hit=%b state=%b prepc=%h cb=%0d cm=%0d",
                 e.name, pc, hit_predict, state, prepc, cnt_branch, cnt_miss);
      end
    end
  end

  // Drive one cycle of inputs and queue the values expected before this cycle's update lands.
  task automatic step(input string nm, input logic nr, input logic [12:0] p,
                      input logic uv, input logic [12:0] up, input logic tk,
                      input logic [12:0] tg, input logic mi,
                      input logic eh, input logic [1:0] es, input logic [12:0] ep,
                      input int ecb, input int ecm);
    exp_t e;
    @(posedge CLK);
    #1;
    NRST = nr; pc = p; upd_valid = uv; upd_pc = up; upd_taken = tk;
    upd_target = tg; upd_mispredict = mi;
    e.cyc = cyc_count; e.name = nm; e.hit = eh; e.st = es; e.pp = ep;
    e.cb = 32'(ecb); e.cm = 32'(ecm);
    q.push_back(e);
  endtask

  initial begin
    NRST = 1'b0; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge CLK);

    // Update asserted during reset must be ignored.
    step("rst_upd",    0, 13'h030, 1, 13'h030, 1, 13'h333, 1, 0, 2'b00, 13'h031, 0, 0);
    step("rst_ignored",1, 13'h030, 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'h031, 0, 0);
    for (int i = 0; i < 128; i++)
      step("rst_sweep", 1, 13'(i), 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'(i + 1), 0, 0);
    step("pc_wrap",    1, 13'h1FFF, 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'h000, 0, 0);

    // Allocation: same-cycle lookup still misses.
    step("alloc_same", 1, 13'h010, 1, 13'h010, 1, 13'h100, 1, 0, 2'b00, 13'h011, 0, 0);
    // Saturation: taken x3 then not-taken x4 (expected = pre-update contents).
    step("sat_t1",     1, 13'h010, 1, 13'h010, 1, 13'h100, 0, 1, 2'b10, 13'h100, 1, 1);
    step("sat_t2",     1, 13'h010, 1, 13'h010, 1, 13'h100, 0, 1, 2'b11, 13'h100, 2, 1);
    step("sat_t3",     1, 13'h010, 1, 13'h010, 1, 13'h100, 0, 1, 2'b11, 13'h100, 3, 1);
    step("sat_n1",     1, 13'h010, 1, 13'h010, 0, 13'h1AA, 0, 1, 2'b11, 13'h100, 4, 1);
    step("sat_n2",     1, 13'h010, 1, 13'h010, 0, 13'h1AA, 0, 1, 2'b10, 13'h100, 5, 1);
    step("sat_n3",     1, 13'h010, 1, 13'h010, 0, 13'h1AA, 0, 1, 2'b01, 13'h100, 6, 1);
    step("sat_n4",     1, 13'h010, 1, 13'h010, 0, 13'h1AA, 0, 1, 2'b00, 13'h100, 7, 1);
    step("sat_floor",  1, 13'h010, 0, 13'h000, 0, 13'h000, 0, 1, 2'b00, 13'h100, 8, 1);

    // Not-taken miss does not allocate.
    step("nt_miss",    1, 13'h020, 1, 13'h020, 0, 13'h055, 1, 0, 2'b00, 13'h021, 8, 1);
    step("nt_noalloc", 1, 13'h020, 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'h021, 9, 2);

    // Aliasing: 0x050 shares index 0x10 with 0x010.
    step("alias_upd",  1, 13'h010, 1, 13'h050, 1, 13'h200, 1, 1, 2'b00, 13'h100, 9, 2);
    step("alias_new",  1, 13'h050, 0, 13'h000, 0, 13'h000, 0, 1, 2'b10, 13'h200, 10, 3);
    step("alias_old",  1, 13'h010, 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'h011, 10, 3);

    // Same-cycle hazard: write visible only next cycle.
    step("haz_same",   1, 13'h030, 1, 13'h030, 1, 13'h333, 0, 0, 2'b00, 13'h031, 10, 3);
    step("haz_next",   1, 13'h030, 0, 13'h000, 0, 13'h000, 0, 1, 2'b10, 13'h333, 11, 3);

    // Mid-run reset discards learned state and ignores the concurrent update.
    step("mid_rst",    0, 13'h030, 1, 13'h030, 1, 13'h444, 1, 1, 2'b10, 13'h333, 11, 3);
    step("post_rst",   1, 13'h030, 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'h031, 0, 0);
    step("post_rst2",  1, 13'h050, 0, 13'h000, 0, 13'h000, 0, 0, 2'b00, 13'h051, 0, 0);

    @(posedge CLK);
    #1;
    upd_valid = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Branch target buffer plus 2-bit saturating direction predictor.
- Supplies the fetch stage's prediction inputs (prepc, hit_predict, state) for the PC currently being fetched.
- Trained by branch resolution from the E stage.
- The fetch stage redirects to prepc when hit_predict & state[1]; this block owns how those three signals are produced and learned.

Parameters:
- PC_W, 13, instruction-word PC width (word addressed, no byte bits).
- IDX_W, 6, index bits; 2^IDX_W direct-mapped entries (64).
- CNT_W, 32, width of the two performance counters.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- NRST  input  1  synchronous active-low reset, sampled on posedge CLK.
- pc  input  PC_W  PC currently being fetched (lookup address).
- prepc  output  PC_W  predicted target on hit, pc+1 on miss.
- hit_predict  output  1  valid entry with matching tag for pc.
- state  output  2  direction counter of the hit entry; 2'b00 on miss.
- upd_valid  input  1  a branch/jump resolved this cycle.
- upd_pc  input  PC_W  PC of the resolved instruction.
- upd_taken  input  1  actual direction.
- upd_target  input  PC_W  actual taken target.
- upd_mispredict  input  1  fetch prediction for this instruction was wrong (same condition that raises fail_predict).
- cnt_branch  output  CNT_W  number of accepted updates.
- cnt_miss  output  CNT_W  number of updates with upd_mispredict=1.

Behaviour:
- Storage, per entry: valid (1), tag (PC_W-IDX_W), target (PC_W), ctr (2).
  - Index = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W].
  - Held in flops/distributed RAM with asynchronous read.
- Lookup is purely combinational from pc, zero cycle latency. This is mandatory because fetch uses the result in the same cycle it selects the next PC.
  - hit_predict = valid[idx] & (tag[idx] == pc tag).
  - Hit: prepc = target[idx], state = ctr[idx].
  - Miss: prepc = pc+1 (wraps mod 2^PC_W), state = 2'b00.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff ctr[1].
- Update, on posedge when upd_valid=1 and NRST=1. Entry u = upd_pc index, tag match as in lookup.
  - Hit & taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit & not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss & taken: allocate/replace entry u. valid=1, tag=upd_pc tag, target=upd_target, ctr=2'b10.
  - Miss & not taken: no change to entry storage.
  - Counters: cnt_branch += 1. cnt_miss += 1 if upd_mispredict. Both wrap at 2^CNT_W.
- One update per cycle max. Updates are never blocked by fetch stall; this block has no stall input.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The write becomes visible on the following cycle; no bypass.
- Reset (NRST=0 at posedge): all valid=0, cnt_branch=0, cnt_miss=0.
  - tag/target/ctr need not be cleared.
  - Any upd_valid in that cycle is ignored.
  - After reset: hit_predict=0, state=2'b00, prepc=pc+1 for every pc.
- Reset mid-run discards all learned state. The first prediction after NRST returns high is always a miss.
- Aliasing: different PCs with equal index evict each other. A tag mismatch never reports a hit.

Test Plan:
- Reset: hold NRST=0 two cycles, sweep pc 0..127 -> hit_predict=0, state=00, prepc=pc+1, cnt_branch=cnt_miss=0. pc=13'h1FFF -> prepc=0.
- Allocation: update upd_pc=0x010, taken, target=0x100, mispredict=1. Next cycle pc=0x010 -> hit_predict=1, state=10, prepc=0x100; cnt_branch=1, cnt_miss=1.
- Saturation: three taken updates at 0x010 -> state 11 and stays 11. Then four not-taken updates -> 10, 01, 00, 00; prepc stays 0x100; hit_predict stays 1.
- No allocation on not-taken miss: update pc=0x020, not taken -> lookup 0x020 misses; cnt_branch increments.
- Aliasing: entry 0x010 present; taken update at 0x050 (same index 0x10), target 0x200 -> lookup 0x050 hits with state 10, prepc=0x200; lookup 0x010 now misses.
- Same-cycle hazard: pc=0x030 while allocating update at 0x030 -> hit_predict=0 that cycle, 1 the next. Update asserted together with NRST=0 -> ignored, counters 0.
